// File: rtl/fu_scheduler_if.sv
// Dispatch, issue and status bundle between the front end / reservation station and fu_scheduler.
// The master side drives dispatch and issue strobes; the slave side (the scheduler) drives status.
interface fu_scheduler_if #(
  parameter int CNT_W = 7
);
  logic             dispatch_valid;
  logic             dispatch_is_mem;
  logic             dispatch_ready;
  logic [1:0]       fu_pos;
  logic [2:0]       issue_valid;
  logic             flush;
  logic [2:0]       fu_table;
  logic [2:0]       fu_done;
  logic [CNT_W-1:0] rs_count;
  logic             rs_full;
  logic             rs_empty;
  logic             issue_err;

  modport master (
    output dispatch_valid, dispatch_is_mem, issue_valid, flush,
    input  dispatch_ready, fu_pos, fu_table, fu_done, rs_count, rs_full, rs_empty, issue_err
  );

  modport slave (
    input  dispatch_valid, dispatch_is_mem, issue_valid, flush,
    output dispatch_ready, fu_pos, fu_table, fu_done, rs_count, rs_full, rs_empty, issue_err
  );
endinterface

// File: rtl/fu_scheduler.sv
// RS occupancy tracker and FU scheduler for ALU0, ALU1 and MEM: load-balanced ALU choice,
// per-FU pending counts, fixed-latency busy tracking, free mask and completion pulses.
module fu_scheduler #(
  parameter int RS_DEPTH = 64,
  parameter int CNT_W    = 7,
  parameter int ALU_LAT  = 1,
  parameter int MEM_LAT  = 3
) (
  input logic           clk,
  input logic           rst,
  fu_scheduler_if.slave bus
);
  localparam int         NUM_FU  = 3;
  localparam int         MAX_LAT = (MEM_LAT > ALU_LAT) ? MEM_LAT : ALU_LAT;
  localparam int         LAT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [1:0] FU_MEM  = 2'd2;

  typedef enum logic {IDLE, BUSY} fu_state_e;

  fu_state_e          state_q [NUM_FU];
  fu_state_e          state_d [NUM_FU];
  logic [LAT_W-1:0]   cnt_q   [NUM_FU];
  logic [LAT_W-1:0]   cnt_d   [NUM_FU];
  logic [CNT_W-1:0]   pend_q  [NUM_FU];
  logic [CNT_W-1:0]   pend_d  [NUM_FU];
  logic [CNT_W-1:0]   count_q, count_d;
  logic               alu_ptr_q, alu_ptr_d;
  logic               err_q, err_d;
  logic [NUM_FU-1:0]  done_q, done_d;
  logic [NUM_FU-1:0]  accept;
  logic               rs_full, dispatch_fire, take, tie, alu_sel;
  logic [1:0]         fu_pos;

  function automatic logic [LAT_W-1:0] lat_load(input int fu);
    return (fu == 2) ? LAT_W'(MEM_LAT - 1) : LAT_W'(ALU_LAT - 1);
  endfunction

  assign rs_full       = (count_q == CNT_W'(RS_DEPTH));
  assign dispatch_fire = bus.dispatch_valid & ~rs_full;
  // A flush squashes the dispatch in the same cycle, including its effect on alu_ptr.
  assign take          = dispatch_fire & ~bus.flush;
  assign tie           = (pend_q[0] == pend_q[1]);
  assign alu_sel       = tie ? alu_ptr_q : (pend_q[1] < pend_q[0]);
  assign fu_pos        = bus.dispatch_is_mem ? FU_MEM : {1'b0, alu_sel};

  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    done_d    = '0;
    accept    = '0;
    err_d     = err_q;
    alu_ptr_d = alu_ptr_q;

    for (int i = 0; i < NUM_FU; i++) begin
      accept[i] = bus.issue_valid[i] && !bus.flush && (state_q[i] == IDLE) && (pend_q[i] != '0);
      if (bus.issue_valid[i] && !bus.flush && !accept[i])
        err_d = 1'b1;

      if (state_q[i] == IDLE) begin
        if (accept[i]) begin
          state_d[i] = BUSY;
          cnt_d[i]   = lat_load(i);
        end
      end else if (cnt_q[i] == '0) begin
        state_d[i] = IDLE;
      end else begin
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end
      // The pulse marks the final busy cycle, so it lines up with issue time + latency.
      done_d[i] = (state_d[i] == BUSY) && (cnt_d[i] == '0);

      if (bus.flush)
        pend_d[i] = '0;
      else if (take && (fu_pos == 2'(i)) && !accept[i])
        pend_d[i] = pend_q[i] + CNT_W'(1);
      else if (accept[i] && !(take && (fu_pos == 2'(i))))
        pend_d[i] = pend_q[i] - CNT_W'(1);
    end

    if (bus.flush)
      count_d = '0;
    else
      count_d = count_q + CNT_W'(take) - CNT_W'($countones(accept));

    if (take && !bus.dispatch_is_mem && tie)
      alu_ptr_d = ~alu_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-FU arrays are control state, not storage, so each element is reset explicitly.
      for (int i = 0; i < NUM_FU; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
        pend_q[i]  <= '0;
      end
      count_q   <= '0;
      alu_ptr_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the same pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      count_q   <= count_d;
      alu_ptr_q <= alu_ptr_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  assign bus.dispatch_ready = ~rs_full;
  assign bus.fu_pos         = fu_pos;
  assign bus.fu_table       = {state_q[2] == IDLE, state_q[1] == IDLE, state_q[0] == IDLE};
  assign bus.fu_done        = done_q;
  assign bus.rs_count       = count_q;
  assign bus.rs_full        = rs_full;
  assign bus.rs_empty       = (count_q == '0);
  assign bus.issue_err      = err_q;
endmodule

// File: tb/tb_fu_scheduler.sv
// Self-checking bench for fu_scheduler: directed scenarios plus a randomized run, all checked
// against a cycle-level reference model built from pending counts and remaining busy cycles.
module tb_fu_scheduler;
  localparam int RS_DEPTH = 64;
  localparam int CNT_W    = 7;
  localparam int ALU_LAT  = 1;
  localparam int MEM_LAT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  fu_scheduler_if #(.CNT_W(CNT_W)) bus ();

  fu_scheduler #(
    .RS_DEPTH (RS_DEPTH),
    .CNT_W    (CNT_W),
    .ALU_LAT  (ALU_LAT),
    .MEM_LAT  (MEM_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: queued work per FU, remaining busy cycles per FU, tie pointer, sticky error.
  int m_pend [3];
  int m_rem  [3];
  bit m_ptr;
  bit m_err;

  function automatic int m_count();
    return m_pend[0] + m_pend[1] + m_pend[2];
  endfunction

  function automatic logic [1:0] m_pos(input logic is_mem);
    if (is_mem) return 2'd2;
    if (m_pend[0] == m_pend[1]) return {1'b0, m_ptr};
    return (m_pend[1] < m_pend[0]) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [2:0] m_table();
    logic [2:0] t;
    for (int i = 0; i < 3; i++) t[i] = (m_rem[i] == 0);
    return t;
  endfunction

  function automatic logic [2:0] m_done();
    logic [2:0] d;
    for (int i = 0; i < 3; i++) d[i] = (m_rem[i] == 1);
    return d;
  endfunction

  task automatic model_step(input logic v, input logic mem, input logic [2:0] iv,
                            input logic fl, input logic r);
    logic [2:0] acc;
    logic [1:0] tgt;
    bit         fire;
    if (r) begin
      for (int i = 0; i < 3; i++) begin m_pend[i] = 0; m_rem[i] = 0; end
      m_ptr = 1'b0;
      m_err = 1'b0;
      return;
    end
    fire = v && (m_count() < RS_DEPTH);
    if (fl) begin
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 0;
        if (m_rem[i] > 0) m_rem[i]--;
      end
      return;
    end
    tgt = m_pos(mem);
    for (int i = 0; i < 3; i++) begin
      acc[i] = iv[i] && (m_rem[i] == 0) && (m_pend[i] > 0);
      if (iv[i] && !acc[i]) m_err = 1'b1;
    end
    if (fire && !mem && (m_pend[0] == m_pend[1])) m_ptr = ~m_ptr;
    for (int i = 0; i < 3; i++) begin
      if (acc[i]) begin
        m_rem[i] = (i == 2) ? MEM_LAT : ALU_LAT;
        m_pend[i]--;
      end else if (m_rem[i] > 0) begin
        m_rem[i]--;
      end
    end
    if (fire) m_pend[tgt]++;
  endtask

  task automatic drive(input logic v, input logic mem, input logic [2:0] iv, input logic fl);
    bus.dispatch_valid  = v;
    bus.dispatch_is_mem = mem;
    bus.issue_valid     = iv;
    bus.flush           = fl;
    #1;
  endtask

  task automatic tick();
    model_step(bus.dispatch_valid, bus.dispatch_is_mem, bus.issue_valid, bus.flush, rst);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.fu_table !== 3'b111) begin n_fail++; $display("FAIL reset_table: got %b want 111", bus.fu_table); end
    n_checks++; if (bus.fu_done !== 3'b000) begin n_fail++; $display("FAIL reset_done: got %b want 000", bus.fu_done); end
    n_checks++; if (bus.rs_count !== 7'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.rs_count); end
    n_checks++; if (bus.rs_empty !== 1'b1 || bus.rs_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%b full=%b want 1 0", bus.rs_empty, bus.rs_full); end
    n_checks++; if (bus.issue_err !== 1'b0 || bus.dispatch_ready !== 1'b1) begin n_fail++; $display("FAIL reset_err_ready: got err=%b ready=%b want 0 1", bus.issue_err, bus.dispatch_ready); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 3'b000, 1'b0);
      n_checks++; if (bus.fu_pos !== m_pos(1'b0)) begin n_fail++; $display("FAIL reset_pos%0d: got %0d want %0d", k, bus.fu_pos, m_pos(1'b0)); end
      tick();
    end
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    n_checks++; if (bus.rs_count !== 7'd3) begin n_fail++; $display("FAIL reset_disp_count: got %0d want 3", bus.rs_count); end
    n_checks++; if (bus.fu_table !== 3'b111) begin n_fail++; $display("FAIL reset_disp_table: got %b want 111", bus.fu_table); end
  endtask

  task automatic test_imbalance();
    do_reset();
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    repeat (5) tick();
    drive(1'b0, 1'b0, 3'b010, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    n_checks++; if (bus.fu_pos !== 2'd1) begin n_fail++; $display("FAIL imbal_pos: got %0d want 1", bus.fu_pos); end
    tick();
    drive(1'b1, 1'b1, 3'b000, 1'b0);
    n_checks++; if (bus.fu_pos !== 2'd2) begin n_fail++; $display("FAIL imbal_mem_pos: got %0d want 2", bus.fu_pos); end
    tick();
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    n_checks++; if (bus.fu_pos !== 2'd1) begin n_fail++; $display("FAIL imbal_ptr_kept: got %0d want 1", bus.fu_pos); end
    n_checks++; if (bus.rs_count !== 7'(m_count())) begin n_fail++; $display("FAIL imbal_count: got %0d want %0d", bus.rs_count, m_count()); end
  endtask

  task automatic test_mem_latency();
    do_reset();
    drive(1'b1, 1'b1, 3'b000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'b100, 1'b0);
    tick();
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 1'b0, 3'b000, 1'b0);
      n_checks++; if (bus.fu_table !== ((k <= 3) ? 3'b011 : 3'b111)) begin n_fail++; $display("FAIL mem_table_t%0d: got %b want %b", k, bus.fu_table, (k <= 3) ? 3'b011 : 3'b111); end
      n_checks++; if (bus.fu_done !== ((k == 3) ? 3'b100 : 3'b000)) begin n_fail++; $display("FAIL mem_done_t%0d: got %b want %b", k, bus.fu_done, (k == 3) ? 3'b100 : 3'b000); end
      n_checks++; if (bus.rs_count !== 7'd0) begin n_fail++; $display("FAIL mem_count_t%0d: got %0d want 0", k, bus.rs_count); end
      tick();
    end
  endtask

  task automatic test_fill();
    do_reset();
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    repeat (66) tick();
    n_checks++; if (bus.rs_count !== 7'd64) begin n_fail++; $display("FAIL fill_count: got %0d want 64", bus.rs_count); end
    n_checks++; if (bus.rs_full !== 1'b1 || bus.dispatch_ready !== 1'b0 || bus.rs_empty !== 1'b0) begin n_fail++; $display("FAIL fill_flags: got full=%b ready=%b empty=%b want 1 0 0", bus.rs_full, bus.dispatch_ready, bus.rs_empty); end
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    n_checks++; if (bus.rs_count !== 7'd63) begin n_fail++; $display("FAIL fill_drain_count: got %0d want 63", bus.rs_count); end
    n_checks++; if (bus.dispatch_ready !== 1'b1 || bus.rs_full !== 1'b0) begin n_fail++; $display("FAIL fill_drain_ready: got ready=%b full=%b want 1 0", bus.dispatch_ready, bus.rs_full); end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    repeat (4) tick();
    drive(1'b0, 1'b0, 3'b010, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'b010, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'b001, 1'b0);
    n_checks++; if (bus.rs_count !== 7'd2 || bus.fu_pos !== 2'd1) begin n_fail++; $display("FAIL same_setup: got count=%0d pos=%0d want 2 1", bus.rs_count, bus.fu_pos); end
    tick();
    drive(1'b0, 1'b0, 3'b001, 1'b0);
    n_checks++; if (bus.rs_count !== 7'd2) begin n_fail++; $display("FAIL same_count: got %0d want 2", bus.rs_count); end
    n_checks++; if (bus.issue_err !== 1'b0 || bus.fu_done !== 3'b001) begin n_fail++; $display("FAIL same_err_done: got err=%b done=%b want 0 001", bus.issue_err, bus.fu_done); end
    tick();
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    n_checks++; if (bus.issue_err !== 1'b1 || bus.rs_count !== 7'd2) begin n_fail++; $display("FAIL busy_issue: got err=%b count=%0d want 1 2", bus.issue_err, bus.rs_count); end
    repeat (3) tick();
    n_checks++; if (bus.issue_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", bus.issue_err); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    drive(1'b1, 1'b1, 3'b000, 1'b0);
    repeat (2) tick();
    drive(1'b1, 1'b0, 3'b000, 1'b0);
    repeat (4) tick();
    drive(1'b0, 1'b0, 3'b100, 1'b0);
    tick();
    drive(1'b1, 1'b0, 3'b011, 1'b1);
    n_checks++; if (bus.rs_count !== 7'd5) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 5", bus.rs_count); end
    tick();
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    n_checks++; if (bus.rs_count !== 7'd0 || bus.rs_empty !== 1'b1) begin n_fail++; $display("FAIL flush_count: got count=%0d empty=%b want 0 1", bus.rs_count, bus.rs_empty); end
    n_checks++; if (bus.fu_table !== 3'b011 || bus.fu_done !== 3'b000 || bus.issue_err !== 1'b0) begin n_fail++; $display("FAIL flush_ignored: got table=%b done=%b err=%b want 011 000 0", bus.fu_table, bus.fu_done, bus.issue_err); end
    tick();
    n_checks++; if (bus.fu_done !== 3'b100) begin n_fail++; $display("FAIL flush_done: got %b want 100", bus.fu_done); end
    tick();
    n_checks++; if (bus.fu_table !== 3'b111 || bus.fu_done !== 3'b000) begin n_fail++; $display("FAIL flush_after: got table=%b done=%b want 111 000", bus.fu_table, bus.fu_done); end
    drive(1'b1, 1'b1, 3'b000, 1'b0);
    tick();
    drive(1'b0, 1'b0, 3'b100, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 1'b0, 3'b000, 1'b1);
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 3'b000, 1'b0);
    n_checks++; if (bus.fu_table !== 3'b111 || bus.rs_count !== 7'd0 || bus.rs_empty !== 1'b1 || bus.issue_err !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got table=%b count=%0d empty=%b err=%b want 111 0 1 0", bus.fu_table, bus.rs_count, bus.rs_empty, bus.issue_err); end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (bus.fu_done !== 3'b000) begin n_fail++; $display("FAIL midrst_done%0d: got %b want 000", k, bus.fu_done); end
      tick();
    end
  endtask

  task automatic test_random();
    logic       v, mem, fl;
    logic [2:0] iv;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      mem = ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 63) == 0);
      iv  = ((c % 200) < 100 || $urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
      drive(v, mem, iv, fl);
      n_checks++; if (bus.fu_pos !== m_pos(mem)) begin n_fail++; $display("FAIL rnd_pos c%0d: got %0d want %0d", c, bus.fu_pos, m_pos(mem)); end
      n_checks++; if (bus.rs_count !== 7'(m_count())) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, bus.rs_count, m_count()); end
      n_checks++; if (bus.rs_full !== (m_count() == RS_DEPTH) || bus.dispatch_ready !== (m_count() != RS_DEPTH)) begin n_fail++; $display("FAIL rnd_full c%0d: got full=%b ready=%b count_model=%0d", c, bus.rs_full, bus.dispatch_ready, m_count()); end
      n_checks++; if (bus.rs_empty !== (m_count() == 0)) begin n_fail++; $display("FAIL rnd_empty c%0d: got %b want %b", c, bus.rs_empty, m_count() == 0); end
      n_checks++; if (bus.fu_table !== m_table()) begin n_fail++; $display("FAIL rnd_table c%0d: got %b want %b", c, bus.fu_table, m_table()); end
      n_checks++; if (bus.fu_done !== m_done()) begin n_fail++; $display("FAIL rnd_done c%0d: got %b want %b", c, bus.fu_done, m_done()); end
      n_checks++; if (bus.issue_err !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d: got %b want %b", c, bus.issue_err, m_err); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_imbalance();
    test_mem_latency();
    test_fill();
    test_back_to_back();
    test_flush_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
